seven_segment_scan: RTL
=======================

# seven_segment_scan

Time-multiplexed driver for the Basys3 four-digit common-anode display, sitting directly downstream of the single-digit hex decoder path. It takes a 16-bit value and per-digit decimal points and scans one digit at a time. A refresh prescaler drives the scan, with an anti-ghosting blank interval at the start of each digit slot. The value is snapshotted once per frame so the display never tears mid-scan.

## Interface
- `TICK_DIV`, default 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz); must be ≥ 2.
- `BLANK_CYCLES`, default 1000: cycles at the start of each slot with all anodes off; must be < `TICK_DIV`.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: scan enable.
- `value` in 16: hex value to display; nibble k goes to digit k, and digit 0 is the rightmost.
- `dp_in` in 4: decimal point request per digit, active-high.
- `an` out 4: anode selects, active-low, with `an[k]` driving digit k.
- `cg,cf,ce,cd,cc,cb,ca` out 1 each: segments, active-low.
- `dp` out 1: decimal-point segment, active-low.
- `frame_start` out 1: single-cycle pulse marking the snapshot load.

## Operation
- State:
  - Prescaler `tick_cnt`: counts 0..`TICK_DIV`-1, then wraps to 0.
  - Digit index `idx`: 2 bits.
  - Snapshot registers: `shadow_val`[15:0] and `shadow_dp`[3:0].
- Advance:
  - On `tick_cnt`==`TICK_DIV`-1, `idx` increments and wraps 3→0.
  - When `idx`==3 wraps, `shadow_val`←`value`, `shadow_dp`←`dp_in`, and `frame_start`=1 for that cycle.
- Slot phases, per digit:
  - BLANK: `tick_cnt` < `BLANK_CYCLES`. Output `an`=4'hF, segments 7'h7F, `dp`=1.
  - SHOW: otherwise. Assert `an[idx]`=0 with all other anodes 1; segments = decode(`shadow_val`[4·idx+3 : 4·idx]); `dp` = ~`shadow_dp[idx]`.
- Decode table (active-low, ordered {cg..ca}), digits 0–F: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E.
- `en`=0: `tick_cnt`, `idx` and the snapshot all hold. Outputs go to the blank pattern and `frame_start` stays 0. When `en` returns to 1, scanning resumes from the held state.
- Snapshot after reset is 0, so the first frame displays "0000". New `value` takes effect only at the next frame start. A `value` change in the same cycle as the wrap is captured.
- Reset mid-operation: all state clears immediately; there is no partial-frame recovery.

## Timing
- `an`, segments, `dp` and `frame_start` are all registered, with one cycle of latency from the counter state.
- Reset values:
  - `an`=4'hF
  - segments=7'h7F
  - `dp`=1
  - `frame_start`=0
  - `tick_cnt`=0, `idx`=0, `shadow_val`=0, `shadow_dp`=0
- Frame period is 4·`TICK_DIV` cycles. Each digit is lit for (`TICK_DIV`−`BLANK_CYCLES`) cycles per frame.
- Anode changes always pass through all-off, so two anodes are never low in the same cycle.
- `frame_start` rises the cycle after the wrap and lasts exactly one cycle. It coincides with the first BLANK output cycle of digit 0.

## Configuration
- `SEVSEG_LZB_EN` defined: leading-zero blanking.
  - Digit 3 is blank if `shadow_val`[15:12]==0.
  - Digit 2 is blank if [15:8]==0.
  - Digit 1 is blank if [15:4]==0.
  - Digit 0 is never blanked, so 0x0000 shows "0".
  - A blanked digit keeps `an`=4'hF for its whole slot and suppresses `dp`.
- Undefined: all four digits are always shown.

## Structure
- Shared package `seven_segment_pkg`: the 16-entry active-low segment table, `SEG_OFF`=7'h7F, and the `digit_idx_t` 2-bit typedef.
- Sub-module `hex7seg_decode`: combinational nibble→7-bit lookup, instantiated once on the muxed nibble.
- The prescaler, index, snapshot, blanking logic and output registers live in `seven_segment_scan`.

## Test plan
All scenarios use `TICK_DIV`=8 and `BLANK_CYCLES`=2.
- Reset: assert `rst` → outputs immediately read `an`=F, segments 7F, `dp`=1; after release, the first frame shows "0" on every digit (segments 40).
- Value display: `value`=16'h1234, wait one frame → digit 0 slot gives `an`=1110/19, digit 1 gives 1101/30, digit 2 gives 1011/24, digit 3 gives 0111/79; each slot opens with 2 cycles of `an`=F.
- Tear-free update: change `value` to 16'hABCD mid-frame → the current frame still shows 1234; the next frame shows D→21, C→46, B→03, A→08; `frame_start` pulses once per 32 cycles.
- Enable and DP: `dp_in`=4'b0100 → `dp`=0 only in digit 2 slots; drop `en` mid-SHOW → `an`=F the next cycle and counters hold; restore `en` → the remaining slot cycles complete.
- Leading-zero blanking (`SEVSEG_LZB_EN`): `value`=16'h0042 → digits 3 and 2 keep `an`=F; `value`=16'h0000 → only digit 0 lights, with segments 40.
- Async reset mid-SHOW: raise `rst` between clock edges → `an`=F without waiting for a clock edge; the snapshot clears.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// Shared types and constants for the four-digit seven-segment scanner.
package seven_segment_pkg;

   typedef logic [1:0] digit_idx_t;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Active-low {cg..ca} patterns for hex digits 0..F.
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational nibble to active-low seven-segment pattern lookup.
module hex7seg_decode
   import seven_segment_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/seven_segment_scan.sv
// Four-digit common-anode scan driver with per-slot blank interval and per-frame snapshot.
// Optional leading-zero blanking when SEVSEG_LZB_EN is defined.
module seven_segment_scan
   import seven_segment_pkg::*;
#(
   parameter int TICK_DIV     = 100000,
   parameter int BLANK_CYCLES = 1000
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] value,
   input  logic [3:0]  dp_in,
   output logic [3:0]  an,
   output logic        cg,
   output logic        cf,
   output logic        ce,
   output logic        cd,
   output logic        cc,
   output logic        cb,
   output logic        ca,
   output logic        dp,
   output logic        frame_start
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] TICK_MAX  = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

   logic [CNT_W-1:0] r_tick_cnt;
   digit_idx_t       r_idx;
   logic [15:0]      r_shadow_val;
   logic [3:0]       r_shadow_dp;
   logic             r_fs_pend;

   logic [3:0]       r_an;
   logic [6:0]       r_seg;
   logic             r_dp;
   logic             r_frame_start;

   logic             w_tick_wrap;
   logic             w_in_blank;
   logic             w_lzb_blank;
   logic [3:0]       w_nibble;
   logic [6:0]       w_seg_dec;
   logic [3:0]       w_an_nxt;
   logic [6:0]       w_seg_nxt;
   logic             w_dp_nxt;

   assign w_tick_wrap = (r_tick_cnt == TICK_MAX);
   assign w_in_blank  = (r_tick_cnt < BLANK_LIM);
   assign w_nibble    = r_shadow_val[{r_idx, 2'b00} +: 4];

   hex7seg_decode u_decode (
      .i_nibble (w_nibble),
      .o_seg    (w_seg_dec)
   );

`ifdef SEVSEG_LZB_EN
   always_comb begin
      w_lzb_blank = 1'b0;
      case (r_idx)
         2'd3:    w_lzb_blank = (r_shadow_val[15:12] == 4'h0);
         2'd2:    w_lzb_blank = (r_shadow_val[15:8]  == 8'h00);
         2'd1:    w_lzb_blank = (r_shadow_val[15:4]  == 12'h000);
         default: w_lzb_blank = 1'b0;
      endcase
   end
`else
   assign w_lzb_blank = 1'b0;
`endif

   always_comb begin
      w_an_nxt  = 4'hF;
      w_seg_nxt = SEG_OFF;
      w_dp_nxt  = 1'b1;
      if (en && !w_in_blank && !w_lzb_blank) begin
         w_an_nxt  = ~(4'b0001 << r_idx);
         w_seg_nxt = w_seg_dec;
         w_dp_nxt  = ~r_shadow_dp[r_idx];
      end
   end

   // The snapshot loads on the 3->0 wrap; the pulse is deferred one cycle so it
   // lines up with the first registered blank cycle of digit 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tick_cnt   <= '0;
         r_idx        <= '0;
         r_shadow_val <= '0;
         r_shadow_dp  <= '0;
         r_fs_pend    <= 1'b0;
      end else if (en) begin
         r_fs_pend <= 1'b0;
         if (w_tick_wrap) begin
            r_tick_cnt <= '0;
            r_idx      <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
               r_shadow_val <= value;
               r_shadow_dp  <= dp_in;
               r_fs_pend    <= 1'b1;
            end
         end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_an          <= 4'hF;
         r_seg         <= SEG_OFF;
         r_dp          <= 1'b1;
         r_frame_start <= 1'b0;
      end else begin
         r_an          <= w_an_nxt;
         r_seg         <= w_seg_nxt;
         r_dp          <= w_dp_nxt;
         r_frame_start <= en && r_fs_pend;
      end
   end

   assign an                           = r_an;
   assign {cg, cf, ce, cd, cc, cb, ca} = r_seg;
   assign dp                           = r_dp;
   assign frame_start                  = r_frame_start;

endmodule
